// File: rtl/reaction_ctrl.sv
// Reaction-time trial sequencer: random wait, GO lamp, timer start/stop on press,
// foul on early press, timeout when the player never responds.
module reaction_ctrl #(
  parameter int          CLKS_PER_MS  = 100000,
  parameter int          MIN_DELAY_MS = 1000,
  parameter logic [15:0] RAND_MASK    = 16'h0FFF,
  parameter int          TIMEOUT_MS   = 9999
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        btn,
  input  logic [13:0] ms_time,
  output logic        timer_start,
  output logic        timer_stop,
  output logic        timer_clr,
  output logic        led_go,
  output logic        foul,
  output logic        timed_out,
  output logic        result_valid,
  output logic [13:0] result_ms,
  output logic [2:0]  state_o
);

  localparam int PW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam int DW = 17;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT    = 3'd1,
    GO      = 3'd2,
    DONE    = 3'd3,
    FOUL    = 3'd4,
    TIMEOUT = 3'd5
  } state_t;

  state_t          state_reg, state_next;
  logic            sync1_reg, sync2_reg, sync3_reg, press_reg;
  logic [15:0]     lfsr_reg;
  logic [DW-1:0]   delay_reg;
  logic [PW-1:0]   presc_reg;
  logic [1:0]      settle_reg;
  logic            result_valid_reg;
  logic [13:0]     result_ms_reg;

  // Two-flop synchronizer, then a registered rising-edge pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      sync3_reg <= 1'b0;
      press_reg <= 1'b0;
    end else begin
      sync1_reg <= btn;
      sync2_reg <= sync1_reg;
      sync3_reg <= sync2_reg;
      press_reg <= sync2_reg & ~sync3_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_reg <= 16'hACE1;
    end else begin
      lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      delay_reg <= '0;
      presc_reg <= '0;
    end else if (state_reg == IDLE && press_reg) begin
      delay_reg <= DW'(MIN_DELAY_MS) + {1'b0, lfsr_reg & RAND_MASK};
      presc_reg <= '0;
    end else if (state_reg == WAIT) begin
      if (presc_reg == PW'(CLKS_PER_MS - 1)) begin
        presc_reg <= '0;
        if (delay_reg != '0) delay_reg <= delay_reg - 1'b1;
      end else begin
        presc_reg <= presc_reg + 1'b1;
      end
    end
  end

  // Give the external timer two cycles to settle after the stop before capturing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_reg       <= 2'd0;
      result_valid_reg <= 1'b0;
      result_ms_reg    <= '0;
    end else begin
      if (state_reg != DONE) settle_reg <= 2'd0;
      else if (settle_reg != 2'd2) settle_reg <= settle_reg + 1'b1;

      if (state_next == IDLE && state_reg != IDLE) begin
        result_valid_reg <= 1'b0;
      end else if (state_reg == DONE && settle_reg == 2'd1) begin
        result_ms_reg    <= ms_time;
        result_valid_reg <= 1'b1;
      end
    end
  end

  // Press always wins over a simultaneous delay expiry or timeout
  always_comb begin
    state_next  = state_reg;
    timer_start = 1'b0;
    timer_stop  = 1'b0;
    case (state_reg)
      IDLE: if (press_reg) state_next = WAIT;
      WAIT: begin
        if (press_reg) begin
          state_next = FOUL;
        end else if (delay_reg == '0) begin
          state_next  = GO;
          timer_start = 1'b1;
        end
      end
      GO: begin
        if (press_reg) begin
          state_next = DONE;
          timer_stop = 1'b1;
        end else if (ms_time == 14'(TIMEOUT_MS)) begin
          state_next = TIMEOUT;
          timer_stop = 1'b1;
        end
      end
      DONE, FOUL, TIMEOUT: if (press_reg) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign timer_clr    = (state_reg == IDLE);
  assign led_go       = (state_reg == GO);
  assign foul         = (state_reg == FOUL);
  assign timed_out    = (state_reg == TIMEOUT);
  assign result_valid = result_valid_reg;
  assign result_ms    = result_ms_reg;
  assign state_o      = state_reg;

endmodule

// File: tb/tb_reaction_ctrl.sv
// Directed bench for reaction_ctrl with a behavioural ms timer and reference LFSR.
module tb_reaction_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn = 1'b0;
  logic [13:0] ms_time;
  logic        timer_start, timer_stop, timer_clr, led_go, foul, timed_out, result_valid;
  logic [13:0] result_ms;
  logic [2:0]  state_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  reaction_ctrl #(
    .CLKS_PER_MS (10),
    .MIN_DELAY_MS(3),
    .RAND_MASK   (16'h0003),
    .TIMEOUT_MS  (9999)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn         (btn),
    .ms_time     (ms_time),
    .timer_start (timer_start),
    .timer_stop  (timer_stop),
    .timer_clr   (timer_clr),
    .led_go      (led_go),
    .foul        (foul),
    .timed_out   (timed_out),
    .result_valid(result_valid),
    .result_ms   (result_ms),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  // Behavioural timer: counts one ms per clk while running; can be forced to 9999
  logic [13:0] tmr_cnt;
  logic        tmr_run;
  logic        force_ms = 1'b0;
  assign ms_time = force_ms ? 14'd9999 : tmr_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr_cnt <= '0;
      tmr_run <= 1'b0;
    end else if (timer_clr) begin
      tmr_cnt <= '0;
      tmr_run <= 1'b0;
    end else if (timer_stop) begin
      tmr_run <= 1'b0;
    end else if (timer_start) begin
      tmr_run <= 1'b1;
    end else if (tmr_run) begin
      tmr_cnt <= tmr_cnt + 14'd1;
    end
  end

  // Reference Fibonacci LFSR (taps 16,14,13,11); lfsr_prev is the value before the last edge
  logic [15:0] lfsr_m, lfsr_prev;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_m    <= 16'hACE1;
      lfsr_prev <= 16'hACE1;
    end else begin
      lfsr_m    <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
      lfsr_prev <= lfsr_m;
    end
  end

  int start_cnt = 0;
  int stop_cnt = 0;
  int both_cnt = 0;
  always @(posedge clk) begin
    if (rst_n) begin
      if (timer_start) start_cnt <= start_cnt + 1;
      if (timer_stop) stop_cnt <= stop_cnt + 1;
      if (timer_start && timer_stop) both_cnt <= both_cnt + 1;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

  task automatic wait_state(input logic [2:0] s, input int bound, output int n);
    n = 0;
    while (state_o !== s && n < bound) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic press_btn();
    btn = 1'b1;
    repeat (4) @(negedge clk);
    btn = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic enter_wait(output int d);
    int n;
    btn = 1'b1;
    wait_state(3'd1, 10, n);
    total_cnt++;
    if (state_o !== 3'd1) $display("FAIL enter_wait: state_o=%0d required 1", state_o);
    else pass_cnt++;
    btn = 1'b0;
    d = 3 + int'(lfsr_prev & 16'h0003);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (50) @(negedge clk);
    total_cnt++;
    if (state_o !== 3'd0) $display("FAIL reset_state: state_o=%0d required 0", state_o);
    else pass_cnt++;
    total_cnt++;
    if (timer_clr !== 1'b1) $display("FAIL reset_clr: timer_clr=%b required 1", timer_clr);
    else pass_cnt++;
    total_cnt++;
    if ({timer_start, timer_stop, led_go, foul, timed_out, result_valid} !== 6'b0)
      $display("FAIL reset_outs: flags=%b required 000000",
               {timer_start, timer_stop, led_go, foul, timed_out, result_valid});
    else pass_cnt++;
    total_cnt++;
    if (result_ms !== 14'd0) $display("FAIL reset_result: result_ms=%0d required 0", result_ms);
    else pass_cnt++;
    $display("reset: idle 50 cycles, state_o=%0d timer_clr=%b", state_o, timer_clr);
  endtask

  task automatic test_go();
    int n, d, base;
    enter_wait(d);
    base = start_cnt;
    wait_state(3'd2, 200, n);
    total_cnt++;
    if (n !== 10 * d + 1) $display("FAIL go_latency: cycles=%0d required %0d", n, 10 * d + 1);
    else pass_cnt++;
    total_cnt++;
    if (state_o !== 3'd2 || led_go !== 1'b1)
      $display("FAIL go_state: state_o=%0d led_go=%b required 2/1", state_o, led_go);
    else pass_cnt++;
    total_cnt++;
    if (start_cnt - base !== 1) $display("FAIL go_start: pulses=%0d required 1", start_cnt - base);
    else pass_cnt++;
    $display("go: delay %0d ms, GO after %0d cycles", d, n);
  endtask

  task automatic test_done();
    int n, sbase, stbase;
    n = 0;
    while (ms_time !== 14'd247 && n < 400) begin
      @(negedge clk);
      n++;
    end
    stbase = stop_cnt;
    sbase  = start_cnt;
    btn = 1'b1;
    wait_state(3'd3, 10, n);
    total_cnt++;
    if (state_o !== 3'd3 || n !== 4) $display("FAIL done_state: state_o=%0d after %0d cycles required 3 after 4", state_o, n);
    else pass_cnt++;
    total_cnt++;
    if (stop_cnt - stbase !== 1 || start_cnt - sbase !== 0)
      $display("FAIL done_pulses: stop=%0d start=%0d required 1/0", stop_cnt - stbase, start_cnt - sbase);
    else pass_cnt++;
    total_cnt++;
    if (led_go !== 1'b0) $display("FAIL done_led: led_go=%b required 0", led_go);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (result_valid !== 1'b0) $display("FAIL done_early_valid: result_valid=%b required 0", result_valid);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (result_valid !== 1'b1 || result_ms < 14'd249 || result_ms > 14'd251)
      $display("FAIL done_result: valid=%b ms=%0d required 1 and 249..251", result_valid, result_ms);
    else pass_cnt++;
    btn = 1'b0;
    repeat (3) @(negedge clk);
    press_btn();
    total_cnt++;
    if (state_o !== 3'd0 || result_valid !== 1'b0 || result_ms < 14'd249 || result_ms > 14'd251)
      $display("FAIL done_to_idle: state_o=%0d valid=%b ms=%0d required 0/0/249..251", state_o, result_valid, result_ms);
    else pass_cnt++;
    $display("done: result_ms=%0d, back to idle", result_ms);
  endtask

  task automatic test_foul();
    int n, d, base;
    enter_wait(d);
    base = start_cnt;
    repeat (5) @(negedge clk);
    btn = 1'b1;
    wait_state(3'd4, 10, n);
    total_cnt++;
    if (state_o !== 3'd4 || foul !== 1'b1 || n !== 4)
      $display("FAIL foul_state: state_o=%0d foul=%b cycles=%0d required 4/1/4", state_o, foul, n);
    else pass_cnt++;
    btn = 1'b0;
    repeat (60) @(negedge clk);
    total_cnt++;
    if (start_cnt - base !== 0 || led_go !== 1'b0 || state_o !== 3'd4)
      $display("FAIL foul_no_start: starts=%0d led_go=%b state_o=%0d required 0/0/4", start_cnt - base, led_go, state_o);
    else pass_cnt++;
    press_btn();
    total_cnt++;
    if (state_o !== 3'd0 || foul !== 1'b0) $display("FAIL foul_to_idle: state_o=%0d foul=%b required 0/0", state_o, foul);
    else pass_cnt++;
    $display("foul: early press in WAIT, back to idle");
  endtask

  task automatic test_timeout();
    int n, d, base;
    enter_wait(d);
    wait_state(3'd2, 200, n);
    total_cnt++;
    if (state_o !== 3'd2) $display("FAIL timeout_go: state_o=%0d required 2", state_o);
    else pass_cnt++;
    base = stop_cnt;
    force_ms = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (state_o !== 3'd5 || timed_out !== 1'b1 || led_go !== 1'b0)
      $display("FAIL timeout_state: state_o=%0d timed_out=%b led_go=%b required 5/1/0", state_o, timed_out, led_go);
    else pass_cnt++;
    total_cnt++;
    if (stop_cnt - base !== 1) $display("FAIL timeout_stop: pulses=%0d required 1", stop_cnt - base);
    else pass_cnt++;
    force_ms = 1'b0;
    press_btn();
    total_cnt++;
    if (state_o !== 3'd0 || timed_out !== 1'b0) $display("FAIL timeout_to_idle: state_o=%0d timed_out=%b required 0/0", state_o, timed_out);
    else pass_cnt++;
    $display("timeout: ms_time=9999 with no press");
  endtask

  task automatic test_same_cycle();
    int n, d, base;
    enter_wait(d);
    base = start_cnt;
    // Press pulse lands in the cycle where the delay reaches zero
    repeat (10 * d - 3) @(negedge clk);
    btn = 1'b1;
    repeat (4) @(negedge clk);
    total_cnt++;
    if (state_o !== 3'd4 || start_cnt - base !== 0)
      $display("FAIL tie_wait: state_o=%0d starts=%0d required 4/0", state_o, start_cnt - base);
    else pass_cnt++;
    btn = 1'b0;
    repeat (3) @(negedge clk);
    press_btn();

    enter_wait(d);
    wait_state(3'd2, 200, n);
    base = stop_cnt;
    btn = 1'b1;
    repeat (3) @(negedge clk);
    force_ms = 1'b1;
    @(negedge clk);
    total_cnt++;
    if (state_o !== 3'd3 || timed_out !== 1'b0 || stop_cnt - base !== 1)
      $display("FAIL tie_go: state_o=%0d timed_out=%b stops=%0d required 3/0/1", state_o, timed_out, stop_cnt - base);
    else pass_cnt++;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (result_valid !== 1'b1 || result_ms !== 14'd9999)
      $display("FAIL tie_result: valid=%b ms=%0d required 1/9999", result_valid, result_ms);
    else pass_cnt++;
    force_ms = 1'b0;
    btn = 1'b0;
    repeat (3) @(negedge clk);
    press_btn();
    $display("same_cycle: press beats delay expiry and timeout");
  endtask

  task automatic test_reset_go();
    int n, d;
    enter_wait(d);
    wait_state(3'd2, 200, n);
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (led_go !== 1'b0 || state_o !== 3'd0 || timer_clr !== 1'b1)
      $display("FAIL reset_async: led_go=%b state_o=%0d timer_clr=%b required 0/0/1", led_go, state_o, timer_clr);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (state_o !== 3'd0 || led_go !== 1'b0) $display("FAIL reset_release: state_o=%0d led_go=%b required 0/0", state_o, led_go);
    else pass_cnt++;
    $display("reset_go: async reset during GO");
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_go();
    test_done();
    test_foul();
    test_timeout();
    test_same_cycle();
    test_reset_go();
    total_cnt++;
    if (both_cnt !== 0) $display("FAIL start_stop_overlap: cycles=%0d required 0", both_cnt);
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
